bec_wb_host: RTL and testbench

Wishbone-slave front end for the BEC core. It lets the management SoC load up to four 163-bit operands and a 163-bit scalar key as 32-bit words, then start the core. It serves the core's operand-load and key-bit requests, and captures the 163-bit result for readback. It sits between the Wishbone bus and the core's control and data buses, in the same position as the LA-driven controller.

---
 rtl/bec_pkg.sv | 43 ++++
 rtl/bec_key_shifter.sv | 51 +++++
 rtl/bec_wb_host.sv | 171 +++++++++++++++++
 tb/tb_bec_wb_host.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bec_pkg.sv
// Shared constants, register map, STATUS layout and FSM encoding for the BEC
// Wishbone host, plus word pack/unpack helpers for 163-bit registers.
package bec_pkg;

    localparam int         BEC_W       = 163;
    localparam int         BEC_WORDS   = 6;
    localparam logic [7:0] BEC_KEY_LEN = 8'd163;

    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_OPER   = 8'h20;
    localparam logic [7:0] OFF_KEY    = 8'hA0;
    localparam logic [7:0] OFF_RESULT = 8'hC0;

    localparam int ST_BUSY    = 0;
    localparam int ST_RVALID  = 1;
    localparam int ST_ERR     = 2;
    localparam int ST_BEC_LSB = 3;
    localparam int ST_LS_LSB  = 7;
    localparam int ST_CNT_LSB = 10;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Word 5 carries only bits [162:160]; the zero extension drops the rest.
    function automatic logic [31:0] get_word(input logic [BEC_W-1:0] v, input logic [2:0] j);
        logic [BEC_W+31:0] ext;
        ext = {32'b0, v};
        return ext[32*j +: 32];
    endfunction

    function automatic logic [BEC_W-1:0] put_word(input logic [BEC_W-1:0] v,
                                                  input logic [2:0]       j,
                                                  input logic [31:0]      d);
        logic [BEC_W+31:0] ext;
        ext = {32'b0, v};
        ext[32*j +: 32] = d;
        return ext[BEC_W-1:0];
    endfunction

endpackage

// File: rtl/bec_key_shifter.sv
// Scalar key storage and the MSB-first key stream presented to the core,
// with a consumed-bit counter and a sticky overflow flag.
module bec_key_shifter
    import bec_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_we,
    input  logic [2:0]       key_widx,
    input  logic [31:0]      key_wdata,
    input  logic             load,
    input  logic             clear,
    input  logic             shift,
    output logic [BEC_W-1:0] key_reg,
    output logic             ki,
    output logic [7:0]       count,
    output logic             overflow
);

    logic [BEC_W-1:0] key_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_reg   <= '0;
            key_shift <= '0;
            count     <= '0;
            overflow  <= 1'b0;
        end else begin
            if (key_we) key_reg <= put_word(key_reg, key_widx, key_wdata);
            if (clear) begin
                count    <= '0;
                overflow <= 1'b0;
            end else if (load) begin
                key_shift <= key_reg;
                count     <= '0;
                overflow  <= 1'b0;
            end else if (shift) begin
                // Once every bit has been consumed further requests only flag an error.
                if (count == BEC_KEY_LEN) begin
                    overflow <= 1'b1;
                end else begin
                    key_shift <= {key_shift[BEC_W-2:0], 1'b0};
                    count     <= count + 8'd1;
                end
            end
        end
    end

    assign ki = key_shift[BEC_W-1];

endmodule

// File: rtl/bec_wb_host.sv
// Wishbone slave front end for the BEC core: operand/key loading, start/clear
// control, operand and key-bit service during a run, and result capture.
module bec_wb_host
    import bec_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter int          NUM_OPERANDS = 4
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             wbs_stb_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    output logic             enable,
    output logic             load_data,
    output logic [BEC_W-1:0] data_out,
    output logic             ki,
    input  logic [2:0]       load_status,
    input  logic             trigLoad,
    input  logic             next_key,
    input  logic [3:0]       becStatus,
    input  logic [BEC_W-1:0] data_in,
    input  logic             done,
    output logic             irq_o
);

    state_t           state, state_nx;
    logic             busy, trig_q, err_q, result_valid, key_ovf;
    logic [BEC_W-1:0] oper [NUM_OPERANDS];
    logic [BEC_W-1:0] result, key_reg, oper_rd, oper_ls;
    logic [7:0]       key_count;
    logic [31:0]      rd_data;

    // Byte lanes and the byte offset within a word are deliberately ignored.
    logic unused_ok;
    assign unused_ok = &{1'b0, wbs_sel_i, wbs_adr_i[1:0]};

    logic [7:0] off;
    logic [2:0] region, widx, oper_idx;
    logic       req, wr, word_ok, is_ctrl, is_status, oper_hit, key_hit, res_hit;
    assign off       = wbs_adr_i[7:0];
    assign region    = off[7:5];
    assign widx      = off[4:2];
    assign oper_idx  = region - OFF_OPER[7:5];
    assign req       = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign wr        = req & wbs_we_i;
    assign word_ok   = int'(widx) < BEC_WORDS;
    assign is_ctrl   = off[7:2] == OFF_CTRL[7:2];
    assign is_status = off[7:2] == OFF_STATUS[7:2];
    assign oper_hit  = word_ok && (int'(oper_idx) < NUM_OPERANDS);
    assign key_hit   = word_ok && (region == OFF_KEY[7:5]);
    assign res_hit   = word_ok && (region == OFF_RESULT[7:5]);

    logic ctrl_wr, start_wr, clear_wr, go, ls_ok, svc;
    assign ctrl_wr  = wr & is_ctrl;
    assign clear_wr = ctrl_wr & wbs_dat_i[1];
    assign start_wr = ctrl_wr & wbs_dat_i[0] & ~wbs_dat_i[1];
    assign go       = start_wr & ~busy;
    assign ls_ok    = int'(load_status) < NUM_OPERANDS;
    // A done in the same cycle as a trigLoad rise ends the run without service.
    assign svc      = busy & trigLoad & ~trig_q & ~done & ~clear_wr;

    always_comb begin
        oper_rd = '0;
        oper_ls = '0;
        for (int i = 0; i < NUM_OPERANDS; i++) begin
            if (oper_idx == 3'(i))    oper_rd = oper[i];
            if (load_status == 3'(i)) oper_ls = oper[i];
        end
    end

    // FSM: state register, next state, outputs.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) state <= S_IDLE;
        else            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (clear_wr) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start_wr) state_nx = S_RUN;
                S_RUN:   if (done)     state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy   = (state == S_RUN);
        enable = busy;
    end

    bec_key_shifter u_key (
        .clk      (wb_clk_i),
        .rst_n    (wb_rst_ni),
        .key_we   (wr & key_hit & ~busy),
        .key_widx (widx),
        .key_wdata(wbs_dat_i),
        .load     (go),
        .clear    (clear_wr),
        .shift    (busy & next_key),
        .key_reg  (key_reg),
        .ki       (ki),
        .count    (key_count),
        .overflow (key_ovf)
    );

    logic [31:0] status;
    always_comb begin
        status                             = '0;
        status[ST_BUSY]                    = busy;
        status[ST_RVALID]                  = result_valid;
        status[ST_ERR]                     = err_q | key_ovf;
        status[ST_BEC_LSB +: 4]            = becStatus;
        status[ST_LS_LSB +: 3]             = load_status;
        status[ST_CNT_LSB +: 8]            = key_count;
        rd_data = '0;
        if (is_status)     rd_data = status;
        else if (oper_hit) rd_data = get_word(oper_rd, widx);
        else if (key_hit)  rd_data = get_word(key_reg, widx);
        else if (res_hit)  rd_data = get_word(result, widx);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbs_ack_o    <= 1'b0;
            wbs_dat_o    <= '0;
            trig_q       <= 1'b0;
            load_data    <= 1'b0;
            data_out     <= '0;
            err_q        <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
            for (int i = 0; i < NUM_OPERANDS; i++) oper[i] <= '0;
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= (req & ~wbs_we_i) ? rd_data : 32'h0;
            trig_q    <= trigLoad;
            load_data <= svc;
            if (svc) data_out <= ls_ok ? oper_ls : '0;

            if (wr & oper_hit & ~busy) begin
                for (int i = 0; i < NUM_OPERANDS; i++)
                    if (oper_idx == 3'(i)) oper[i] <= put_word(oper[i], widx, wbs_dat_i);
            end

            if (clear_wr | go)
                err_q <= 1'b0;
            else if ((busy & wr & (oper_hit | key_hit)) | (svc & ~ls_ok))
                err_q <= 1'b1;

            if (clear_wr | go) begin
                result_valid <= 1'b0;
            end else if (busy & done) begin
                result_valid <= 1'b1;
                result       <= data_in;
            end
        end
    end

    assign irq_o = result_valid;

endmodule

// File: tb/tb_bec_wb_host.sv
// Directed bench for bec_wb_host: register reads are checked by a scoreboard
// monitor on ack; core-side strobes are checked directly at negedges.
module tb_bec_wb_host;
    import bec_pkg::*;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]       sel = 4'hF;
    logic [31:0]      adr = '0, dat_w = '0;
    logic             ack;
    logic [31:0]      dat_r;
    logic             enable, load_data, ki, irq;
    logic [BEC_W-1:0] data_out;
    logic [2:0]       load_status = '0;
    logic             trig_load = 1'b0, next_key = 1'b0, done = 1'b0;
    logic [3:0]       bec_status = 4'hA;
    logic [BEC_W-1:0] data_in = '0;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    string       nm_q[$];
    bit          kind_q[$];
    logic        ack_prev = 1'b0;

    bec_wb_host dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .wbs_stb_i  (stb),
        .wbs_cyc_i  (cyc),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (dat_w),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (dat_r),
        .enable     (enable),
        .load_data  (load_data),
        .data_out   (data_out),
        .ki         (ki),
        .load_status(load_status),
        .trigLoad   (trig_load),
        .next_key   (next_key),
        .becStatus  (bec_status),
        .data_in    (data_in),
        .done       (done),
        .irq_o      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [BEC_W-1:0] act, input logic [BEC_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every ack must be one cycle wide; read acks are scored against exp_q.
    always @(negedge clk) begin
        if (!rst_n) begin
            ack_prev = 1'b0;
        end else begin
            if (ack) begin
                check("ack_width", ack_prev, 1'b0);
                if (kind_q.size() == 0) begin
                    check("unexpected_ack", 1'b1, 1'b0);
                end else if (kind_q.pop_front()) begin
                    check(nm_q.pop_front(), dat_r, exp_q.pop_front());
                end
            end
            ack_prev = ack;
        end
    end

    task automatic access(input logic [7:0] off, input logic w, input logic [31:0] d);
        bit got;
        got = 0;
        @(negedge clk);
        stb = 1; cyc = 1; we = w; adr = BASE | {24'h0, off}; dat_w = d;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack) begin got = 1; break; end
        end
        stb = 0; cyc = 0; we = 0;
        if (!got) begin
            check("ack_timeout", 1'b0, 1'b1);
            if (kind_q.pop_back()) begin
                void'(exp_q.pop_back());
                void'(nm_q.pop_back());
            end
        end
    endtask

    task automatic wb_write(input logic [7:0] off, input logic [31:0] d);
        kind_q.push_back(1'b0);
        access(off, 1'b1, d);
    endtask

    task automatic wb_read(input logic [7:0] off, input logic [31:0] exp, input string nm);
        kind_q.push_back(1'b1);
        exp_q.push_back(exp);
        nm_q.push_back(nm);
        access(off, 1'b0, 32'h0);
    endtask

    task automatic wb_noack(input logic [31:0] a);
        bit seen;
        seen = 0;
        @(negedge clk);
        stb = 1; cyc = 1; we = 0; adr = a;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ack) seen = 1;
        end
        stb = 0; cyc = 0;
        check("out_of_range_ack", seen, 1'b0);
    endtask

    task automatic pulse_key(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); next_key = 1;
            @(negedge clk); next_key = 0;
        end
    endtask

    task automatic raise_trig(input logic [2:0] ls);
        @(negedge clk); load_status = ls; trig_load = 1;
        @(negedge clk);
    endtask

    logic [BEC_W-1:0] op2_exp;

    initial begin
        op2_exp = {3'h7, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1};
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        check("rst_enable", enable, 1'b0);
        check("rst_load_data", load_data, 1'b0);
        check("rst_ki", ki, 1'b0);
        check("rst_irq", irq, 1'b0);
        check("rst_data_out", data_out, '0);
        wb_read(8'h04, 32'h0000_0050, "rst_status");

        // Operand 2 load and readback; word 5 keeps only three bits.
        for (int j = 0; j < 6; j++)
            wb_write(8'h60 + 8'(4 * j), (j == 5) ? 32'hFFFF_FFFF : 32'(j + 1));
        for (int j = 0; j < 6; j++)
            wb_read(8'h60 + 8'(4 * j), (j == 5) ? 32'h7 : 32'(j + 1), $sformatf("op2_w%0d", j));
        wb_read(8'h10, 32'h0, "unmapped_read");
        wb_read(8'h98, 32'h0, "op3_word6_read");
        wb_read(8'h00, 32'h0, "ctrl_read");
        wb_noack(32'h3000_0104);

        // Key with bit 162 and bit 0 set.
        wb_write(8'hA0, 32'h1);
        wb_write(8'hB4, 32'h4);
        wb_read(8'hB4, 32'h4, "key_w5");

        wb_write(8'h00, 32'h1);
        check("start_enable", enable, 1'b1);
        check("start_ki", ki, 1'b1);
        wb_read(8'h04, 32'h0000_0051, "run_status");

        // Operand service.
        raise_trig(3'd2);
        check("svc_load_data", load_data, 1'b1);
        check("svc_data_out", data_out, op2_exp);
        @(negedge clk);
        check("svc_one_cycle", load_data, 1'b0);
        trig_load = 0;
        raise_trig(3'd5);
        check("bad_ls_load_data", load_data, 1'b1);
        check("bad_ls_data_out", data_out, '0);
        trig_load = 0;
        wb_read(8'h04, 32'h0000_02D5, "bad_ls_status");

        // Clear and restart for the key stream.
        load_status = 3'd0;
        wb_write(8'h00, 32'h2);
        check("clear_enable", enable, 1'b0);
        wb_write(8'h00, 32'h1);
        check("restart_ki", ki, 1'b1);
        pulse_key(1);
        check("key1_ki", ki, 1'b0);
        pulse_key(161);
        check("key162_ki", ki, 1'b1);
        wb_read(8'h04, 32'h0002_8851, "key162_status");
        pulse_key(1);
        check("key163_ki", ki, 1'b0);
        wb_read(8'h04, 32'h0002_8C51, "key163_status");
        pulse_key(1);
        wb_read(8'h04, 32'h0002_8C55, "key164_status");

        // Completion.
        data_in = '1;
        @(negedge clk); done = 1;
        @(negedge clk); done = 0;
        check("done_irq", irq, 1'b1);
        check("done_enable", enable, 1'b0);
        wb_read(8'h04, 32'h0002_8C56, "done_status");
        for (int j = 0; j < 6; j++)
            wb_read(8'hC0 + 8'(4 * j), (j == 5) ? 32'h7 : 32'hFFFF_FFFF, $sformatf("res_w%0d", j));
        wb_write(8'h00, 32'h1);
        check("restart_irq", irq, 1'b0);

        // done and trigLoad rise together.
        @(negedge clk); load_status = 3'd1; trig_load = 1; done = 1;
        @(negedge clk); done = 0;
        check("collide_load_data", load_data, 1'b0);
        check("collide_irq", irq, 1'b1);
        trig_load = 0;

        // Restart, then a second start while busy must not reset the counter.
        wb_write(8'h00, 32'h1);
        pulse_key(2);
        wb_write(8'h00, 32'h1);
        wb_read(8'h04, 32'h0000_08D1, "restart_busy_status");
        wb_write(8'h20, 32'h1234);
        wb_read(8'h04, 32'h0000_08D5, "busy_write_status");
        wb_write(8'h00, 32'h3);
        check("ctrl3_enable", enable, 1'b0);
        wb_read(8'h04, 32'h0000_00D0, "ctrl3_status");
        wb_read(8'h20, 32'h0, "busy_write_dropped");

        // Reset mid-run.
        wb_write(8'h00, 32'h1);
        check("prerst_enable", enable, 1'b1);
        @(negedge clk);
        rst_n = 0;
        #1;
        check("async_rst_enable", enable, 1'b0);
        @(negedge clk);
        rst_n = 1;
        bec_status = 4'h0;
        load_status = 3'd0;
        @(negedge clk);
        check("postrst_ack", ack, 1'b0);
        check("postrst_irq", irq, 1'b0);
        wb_read(8'h04, 32'h0, "postrst_status");
        wb_read(8'h20, 32'h0, "postrst_op0");
        wb_read(8'h60, 32'h0, "postrst_op2");

        repeat (3) @(negedge clk);
        check("queue_drain", 163'(kind_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
